// File: rtl/gray_stream_decoder.sv
// -----------------------------------------------------------------------------
// gray_stream_decoder
//
// Decodes a stream of 4-bit reflected-binary Gray samples and tracks motion.
// Every accepted sample is decoded to binary and compared with the previously
// accepted value (the reference):
//   +1 mod 16 -> up pulse, position +1
//   -1 mod 16 -> down pulse, position -1
//    0        -> no flag
//   otherwise -> step_err pulse, error counters advance
// ERR_LIMIT consecutive step errors drop the lock. The next sample then
// re-establishes the reference without producing a step flag.
// All outputs are registered and have one cycle of latency.
//
// Ports
//   clk        in   1  single clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   in_valid   in   1  in_gray carries a new sample this cycle
//   in_gray    in   4  Gray-coded sample
//   out_valid  out  1  one-cycle pulse; outputs reflect last cycle's sample
//   out_bin    out  4  binary value of the last accepted sample
//   up         out  1  last sample was reference +1 mod 16
//   down       out  1  last sample was reference -1 mod 16
//   step_err   out  1  last sample was an illegal step
//   locked     out  1  decoder holds a valid reference
//   pos        out  8  signed position accumulator, wraps modulo 256
//   err_count  out  8  total illegal steps, saturates at 255
// -----------------------------------------------------------------------------
module gray_stream_decoder #(
    parameter int ERR_LIMIT = 3   // legal range 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_gray,
    output logic       out_valid,
    output logic [3:0] out_bin,
    output logic       up,
    output logic       down,
    output logic       step_err,
    output logic       locked,
    output logic [7:0] pos,
    output logic [7:0] err_count
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        TRACKING = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);

    state_t     state;
    logic [3:0] ref_val;
    logic [3:0] consec;
    logic [3:0] dec_bin;
    logic [3:0] delta;

    // Each binary bit is the XOR of its Gray bit and all Gray bits above it.
    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    always_comb begin
        dec_bin = gray2bin(in_gray);
        // 4-bit subtraction wraps naturally, giving (new - ref) mod 16.
        delta   = dec_bin - ref_val;
    end

    assign locked = (state == TRACKING);

    // NOTE: every register below is assigned with <= so all of them sample
    // the pre-edge values; blocking assignments here would let later lines
    // see already-updated state and create ordering-dependent behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= UNLOCKED;
            ref_val   <= '0;
            consec    <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            up        <= 1'b0;
            down      <= 1'b0;
            step_err  <= 1'b0;
            pos       <= '0;
            err_count <= '0;
        end else begin
            // Step flags are single-cycle pulses; they are set again below
            // only when an accepted sample calls for one.
            out_valid <= in_valid;
            up        <= 1'b0;
            down      <= 1'b0;
            step_err  <= 1'b0;

            if (in_valid) begin
                out_bin <= dec_bin;
                // Reference follows every accepted sample, even illegal ones.
                ref_val <= dec_bin;

                case (state)
                    UNLOCKED: begin
                        state  <= TRACKING;
                        consec <= '0;
                    end
                    TRACKING: begin
                        if (delta == 4'd0) begin
                            consec <= '0;
                        end else if (delta == 4'd1) begin
                            up     <= 1'b1;
                            pos    <= pos + 8'd1;
                            consec <= '0;
                        end else if (delta == 4'd15) begin
                            down   <= 1'b1;
                            pos    <= pos - 8'd1;
                            consec <= '0;
                        end else begin
                            step_err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                            if (consec + 4'd1 == LIMIT) begin
                                state  <= UNLOCKED;
                                consec <= '0;
                            end else begin
                                consec <= consec + 4'd1;
                            end
                        end
                    end
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_gray_stream_decoder
//
// Directed bench for gray_stream_decoder (ERR_LIMIT = 3). A table of
// {input, expected outputs} records walks through locking, up/down steps,
// the 15<->0 wrap, step errors, loss of lock and re-lock. Hand-written
// sequences then cover reset during a valid sample, the position wrap in
// both directions and error counter saturation.
// -----------------------------------------------------------------------------
module tb_gray_stream_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_gray;
    logic       out_valid;
    logic [3:0] out_bin;
    logic       up;
    logic       down;
    logic       step_err;
    logic       locked;
    logic [7:0] pos;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_stream_decoder #(.ERR_LIMIT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_gray   (in_gray),
        .out_valid (out_valid),
        .out_bin   (out_bin),
        .up        (up),
        .down      (down),
        .step_err  (step_err),
        .locked    (locked),
        .pos       (pos),
        .err_count (err_count)
    );

    typedef struct {
        logic       vld;
        logic [3:0] gray;
        logic       e_valid;
        logic [3:0] e_bin;
        logic       e_up;
        logic       e_down;
        logic       e_err;
        logic       e_locked;
        logic [7:0] e_pos;
        logic [7:0] e_errc;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic vld, input logic [3:0] gray,
                                input logic ev, input logic [3:0] eb,
                                input logic eu, input logic ed, input logic ee,
                                input logic el, input logic [7:0] ep,
                                input logic [7:0] ec);
        vec_t v;
        v.vld = vld; v.gray = gray; v.e_valid = ev; v.e_bin = eb;
        v.e_up = eu; v.e_down = ed; v.e_err = ee; v.e_locked = el;
        v.e_pos = ep; v.e_errc = ec;
        return v;
    endfunction

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one cycle of input on the falling edge, then sample the
    // registered outputs just after the following rising edge.
    task automatic cycle(input logic r, input logic v, input logic [3:0] g);
        @(negedge clk);
        reset    = r;
        in_valid = v;
        in_gray  = g;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_valid));
        check({tag, ".out_bin"},   32'(out_bin),   32'(v.e_bin));
        check({tag, ".up"},        32'(up),        32'(v.e_up));
        check({tag, ".down"},      32'(down),      32'(v.e_down));
        check({tag, ".step_err"},  32'(step_err),  32'(v.e_err));
        check({tag, ".locked"},    32'(locked),    32'(v.e_locked));
        check({tag, ".pos"},       32'(pos),       32'(v.e_pos));
        check({tag, ".err_count"}, 32'(err_count), 32'(v.e_errc));
    endtask

    initial begin
        //          vld gray     v  bin    up dn er lk pos    errc
        vecs[0]  = mk(1, 4'b0000, 1, 4'd0,  0, 0, 0, 1, 8'h00, 8'd0); // lock
        vecs[1]  = mk(1, 4'b0001, 1, 4'd1,  1, 0, 0, 1, 8'h01, 8'd0);
        vecs[2]  = mk(1, 4'b0011, 1, 4'd2,  1, 0, 0, 1, 8'h02, 8'd0);
        vecs[3]  = mk(1, 4'b0010, 1, 4'd3,  1, 0, 0, 1, 8'h03, 8'd0);
        vecs[4]  = mk(0, 4'b0000, 0, 4'd3,  0, 0, 0, 1, 8'h03, 8'd0); // idle
        vecs[5]  = mk(1, 4'b0011, 1, 4'd2,  0, 1, 0, 1, 8'h02, 8'd0);
        vecs[6]  = mk(1, 4'b0001, 1, 4'd1,  0, 1, 0, 1, 8'h01, 8'd0);
        vecs[7]  = mk(1, 4'b0000, 1, 4'd0,  0, 1, 0, 1, 8'h00, 8'd0);
        vecs[8]  = mk(1, 4'b1000, 1, 4'd15, 0, 1, 0, 1, 8'hFF, 8'd0); // 0->15
        vecs[9]  = mk(1, 4'b1000, 1, 4'd15, 0, 0, 0, 1, 8'hFF, 8'd0); // hold
        vecs[10] = mk(1, 4'b0000, 1, 4'd0,  1, 0, 0, 1, 8'h00, 8'd0); // 15->0
        vecs[11] = mk(1, 4'b0100, 1, 4'd7,  0, 0, 1, 1, 8'h00, 8'd1); // err 1
        vecs[12] = mk(1, 4'b0000, 1, 4'd0,  0, 0, 1, 1, 8'h00, 8'd2); // err 2
        vecs[13] = mk(1, 4'b0100, 1, 4'd7,  0, 0, 1, 0, 8'h00, 8'd3); // unlock
        vecs[14] = mk(1, 4'b0111, 1, 4'd5,  0, 0, 0, 1, 8'h00, 8'd3); // relock
        vecs[15] = mk(1, 4'b0000, 1, 4'd0,  0, 0, 1, 1, 8'h00, 8'd4);
        vecs[16] = mk(1, 4'b0001, 1, 4'd1,  1, 0, 0, 1, 8'h01, 8'd4); // clears run
        vecs[17] = mk(1, 4'b0100, 1, 4'd7,  0, 0, 1, 1, 8'h01, 8'd5);
        vecs[18] = mk(1, 4'b0000, 1, 4'd0,  0, 0, 1, 1, 8'h01, 8'd6); // still locked
        vecs[19] = mk(1, 4'b0001, 1, 4'd1,  1, 0, 0, 1, 8'h02, 8'd6);
        vecs[20] = mk(0, 4'b0000, 0, 4'd1,  0, 0, 0, 1, 8'h02, 8'd6); // idle

        reset = 1'b1; in_valid = 1'b0; in_gray = 4'b0000;

        // Reset state.
        cycle(1, 0, 4'b0000);
        cycle(1, 0, 4'b0000);
        check_all("reset", mk(0, 4'b0000, 0, 4'd0, 0, 0, 0, 0, 8'h00, 8'd0));

        for (int i = 0; i < NVEC; i++) begin
            cycle(0, vecs[i].vld, vecs[i].gray);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while a valid sample is presented: sample is discarded.
        cycle(1, 1, 4'b0011);
        check("rst_mid.out_valid", 32'(out_valid), 32'd0);
        check("rst_mid.pos",       32'(pos),       32'd0);
        check("rst_mid.err_count", 32'(err_count), 32'd0);
        check("rst_mid.locked",    32'(locked),    32'd0);
        cycle(0, 0, 4'b0000);
        check("rst_mid.after_valid",  32'(out_valid), 32'd0);
        check("rst_mid.after_locked", 32'(locked),    32'd0);

        // 130 up-steps after lock: 127 -> -128 wrap, ending at -126 (0x82).
        cycle(0, 1, bin2gray(4'd0));
        check("upwrap.lock_pos", 32'(pos), 32'd0);
        for (int k = 1; k <= 130; k++) begin
            cycle(0, 1, bin2gray(4'(k)));
            if (k == 127) check("upwrap.pos127", 32'(pos), 32'h7F);
            if (k == 128) check("upwrap.pos128", 32'(pos), 32'h80);
        end
        check("upwrap.final_pos", 32'(pos), 32'h82);
        check("upwrap.up",        32'(up),  32'd1);

        // 129 down-steps after reset and lock: -128 -> 127 wrap.
        cycle(1, 0, 4'b0000);
        cycle(0, 1, bin2gray(4'd0));
        for (int k = 1; k <= 129; k++) begin
            cycle(0, 1, bin2gray(4'(16 - (k % 16))));
            if (k == 128) check("dnwrap.pos128", 32'(pos), 32'h80);
        end
        check("dnwrap.final_pos", 32'(pos),  32'h7F);
        check("dnwrap.down",      32'(down), 32'd1);

        // Alternating bins 0/7 from reset: the first sample locks, then three
        // errors per four samples; 400 samples give 300 errors -> saturate.
        cycle(1, 0, 4'b0000);
        for (int k = 0; k < 400; k++) begin
            cycle(0, 1, (k % 2 == 0) ? bin2gray(4'd0) : bin2gray(4'd7));
        end
        check("sat.err_count", 32'(err_count), 32'd255);
        check("sat.pos",       32'(pos),       32'd0);

        cycle(0, 0, 4'b0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
